// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width, funct3 opcodes and the response-slot state encoding.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; output is zero when alu_en is low.
module alu
    import alu_pkg::*;
(
    input  logic            alu_en,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            funct7_4,
    input  logic            alu_imm,
    output logic [XLEN-1:0] alu_out
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        alu_out = '0;
        if (alu_en) begin
            case (funct3)
                // ADDI has no SUB form, so funct7_4 only matters for register ops
                F3_ADD:  alu_out = (funct7_4 && !alu_imm) ? (a - b) : (a + b);
                F3_SLL:  alu_out = a << shamt;
                F3_SLT:  alu_out = {{(XLEN-1){1'b0}}, lt_signed};
                F3_SLTU: alu_out = {{(XLEN-1){1'b0}}, lt_unsigned};
                F3_XOR:  alu_out = a ^ b;
                F3_SR:   alu_out = funct7_4 ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
                F3_OR:   alu_out = a | b;
                F3_AND:  alu_out = a & b;
                default: alu_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a single
// registered response slot tagged by requester ID.
module alu_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_funct7_4,
    input  logic            req0_imm,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_funct7_4,
    input  logic            req1_imm,

    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    input  logic            rsp_ready
);

    import alu_pkg::*;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    logic            can_accept;
    logic            gnt_valid;
    logic            gnt_id;

    logic [XLEN-1:0] alu_a, alu_b, alu_out;
    logic [2:0]      alu_funct3;
    logic            alu_funct7_4, alu_imm;

    assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
    // Reset suppresses the grant so nothing is accepted into a slot that is being cleared
    assign gnt_valid  = can_accept && !rst && (req0_valid || req1_valid);
    assign gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    assign req0_ready = gnt_valid && !gnt_id;
    assign req1_ready = gnt_valid && gnt_id;

    assign alu_a        = gnt_id ? req1_a        : req0_a;
    assign alu_b        = gnt_id ? req1_b        : req0_b;
    assign alu_funct3   = gnt_id ? req1_funct3   : req0_funct3;
    assign alu_funct7_4 = gnt_id ? req1_funct7_4 : req0_funct7_4;
    assign alu_imm      = gnt_id ? req1_imm      : req0_imm;

    alu u_alu (
        .alu_en   (1'b1),
        .a        (alu_a),
        .b        (alu_b),
        .funct3   (alu_funct3),
        .funct7_4 (alu_funct7_4),
        .alu_imm  (alu_imm),
        .alu_out  (alu_out)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (gnt_valid) begin
            // A grant while FULL && rsp_ready overwrites the drained slot in the same edge
            state_d    = ST_FULL;
            rsp_data_d = alu_out;
            rsp_id_d   = gnt_id;
            ptr_d      = ~gnt_id;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs change at the falling edge, readies are checked
// just after, registered outputs are checked 1 time unit after the rising edge.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_funct7_4, req0_imm;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_funct3;
    logic        req1_valid, req1_ready, req1_funct7_4, req1_imm;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_funct3;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_funct3   (req0_funct3),
        .req0_funct7_4 (req0_funct7_4),
        .req0_imm      (req0_imm),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_funct3   (req1_funct3),
        .req1_funct7_4 (req1_funct7_4),
        .req1_imm      (req1_imm),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7, input logic imm);
        req0_valid = v; req0_a = a; req0_b = b;
        req0_funct3 = f3; req0_funct7_4 = f7; req0_imm = imm;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7, input logic imm);
        req1_valid = v; req1_a = a; req1_b = b;
        req1_funct3 = f3; req1_funct7_4 = f7; req1_imm = imm;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [31:0] data);
        chk({tag, "_valid"}, {31'b0, rsp_valid}, {31'b0, v});
        chk({tag, "_id"},    {31'b0, rsp_id},    {31'b0, id});
        chk({tag, "_data"},  rsp_data,           data);
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_rdy0"}, {31'b0, req0_ready}, {31'b0, r0});
        chk({tag, "_rdy1"}, {31'b0, req1_ready}, {31'b0, r1});
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set0(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive_edge();
        drive_edge();
        check_rsp("reset", 1'b0, 1'b0, 32'h0);

        // Single request: ADD 3+7
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        set0(1'b1, 32'd3, 32'd7, 3'd0, 1'b0, 1'b0);
        #1;
        check_rdy("add", 1'b1, 1'b0);
        drive_edge();
        check_rsp("add", 1'b1, 1'b0, 32'h0000000A);
        @(negedge clk);
        set0(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive_edge();
        check_rsp("drain1", 1'b0, 1'b0, 32'h0000000A);

        // Reset restores pointer to 0 so fairness starts with port 0
        @(negedge clk);
        rst = 1'b1;
        drive_edge();
        @(negedge clk);
        rst = 1'b0;
        set0(1'b1, 32'd1, 32'd1, 3'd0, 1'b1, 1'b0);
        set1(1'b1, 32'h21212121, 32'd14, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy("fair", (i % 2) == 0, (i % 2) == 1);
            drive_edge();
            if ((i % 2) == 0) check_rsp("fair", 1'b1, 1'b0, 32'h00000000);
            else              check_rsp("fair", 1'b1, 1'b1, 32'h48484000);
            @(negedge clk);
        end
        set0(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        set1(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive_edge();
        check_rsp("drain2", 1'b0, 1'b1, 32'h48484000);

        // Backpressure: SRA result held while rsp_ready=0, pending req0 waits
        @(negedge clk);
        set1(1'b1, 32'h80000001, 32'd1, 3'd5, 1'b1, 1'b0);
        #1;
        check_rdy("sra", 1'b0, 1'b1);
        drive_edge();
        check_rsp("sra", 1'b1, 1'b1, 32'hC0000000);
        @(negedge clk);
        set1(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        set0(1'b1, 32'd5, 32'd6, 3'd0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rdy("hold", 1'b0, 1'b0);
            drive_edge();
            check_rsp("hold", 1'b1, 1'b1, 32'hC0000000);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        drive_edge();
        check_rsp("release", 1'b1, 1'b0, 32'd11);

        // Immediate ADD ignores funct7_4; unsigned and signed compares
        @(negedge clk);
        set0(1'b1, 32'd1, 32'd1, 3'd0, 1'b1, 1'b1);
        drive_edge();
        check_rsp("addi", 1'b1, 1'b0, 32'h00000002);
        @(negedge clk);
        set0(1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 3'd3, 1'b0, 1'b0);
        drive_edge();
        check_rsp("sltu", 1'b1, 1'b0, 32'h00000000);
        @(negedge clk);
        set0(1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 3'd2, 1'b0, 1'b0);
        drive_edge();
        check_rsp("slt", 1'b1, 1'b0, 32'h00000001);

        // Reset while FULL: fill with XOR (pointer -> 1), then reset with both ports asking
        @(negedge clk);
        set0(1'b1, 32'hF0F0F0F0, 32'hFFFF0000, 3'd4, 1'b0, 1'b0);
        drive_edge();
        check_rsp("xor", 1'b1, 1'b0, 32'h0F0FF0F0);
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_edge();
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        set1(1'b1, 32'd9, 32'd9, 3'd0, 1'b0, 1'b0);
        #1;
        check_rdy("inrst", 1'b0, 1'b0);
        drive_edge();
        check_rsp("postrst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_rdy("ptr0", 1'b1, 1'b0);
        drive_edge();
        check_rsp("ptr0", 1'b1, 1'b0, 32'h0F0FF0F0);

        // Single-requester streaming on port 1
        @(negedge clk);
        set0(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, 32'h000000F0, 32'(i), 3'd6, 1'b0, 1'b0);
            #1;
            check_rdy("stream", 1'b0, 1'b1);
            drive_edge();
            check_rsp("stream", 1'b1, 1'b1, 32'h000000F0 | 32'(i));
            @(negedge clk);
        end
        set1(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive_edge();
        check_rsp("final", 1'b0, 1'b1, 32'h000000F3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
